// File: rtl/renkon_conv_ctrl_pkg.sv
// rtl/renkon_conv_ctrl_pkg.sv - shared constants, FSM state type and saturating add
//
// Purpose: datapath width, kernel size and latencies shared by the
// convolution sequencer and its delay line, plus the signed saturating adder
// used by the channel accumulator.
package renkon_conv_ctrl_pkg;

  localparam int DWIDTH   = 16;
  localparam int FSIZE    = 5;
  localparam int TREE_LAT = 5;
  localparam int BUF_LAT  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } ctrl_state_t;

  // Sum at DWIDTH+1 bits; the two top bits differ exactly when the result
  // left the signed DWIDTH range, and the top bit tells which side.
  function automatic logic signed [DWIDTH-1:0] sat_add(
    input logic signed [DWIDTH-1:0] a,
    input logic signed [DWIDTH-1:0] b
  );
    logic signed [DWIDTH:0] s;
    s = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
    if (s[DWIDTH] != s[DWIDTH-1]) begin
      sat_add = s[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
    end else begin
      sat_add = s[DWIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/renkon_conv_ctrl_pipe.sv
// rtl/renkon_conv_ctrl_pipe.sv - valid/tag delay line matching buffer plus tree latency
//
// Purpose: carries {valid, first, last, addr} of each issued window for DEPTH
// cycles so the tag arrives alongside the matching tree result.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_first/in_last      tag of the window issued this cycle
//   in_addr   [AWIDTH]             output pixel address of that window
//   out_valid/out_first/out_last   tag leaving the line this cycle
//   out_addr  [AWIDTH]             address leaving the line this cycle
//   empty                          no valid entry anywhere in the line
module renkon_conv_ctrl_pipe
  import renkon_conv_ctrl_pkg::*;
#(
  parameter int DEPTH  = BUF_LAT + TREE_LAT,
  parameter int AWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [AWIDTH-1:0] in_addr,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic [AWIDTH-1:0] out_addr,
  output logic              empty
);

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  f;
  logic [DEPTH-1:0]  l;
  logic [AWIDTH-1:0] a [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      f <= '0;
      l <= '0;
      for (int i = 0; i < DEPTH; i++) a[i] <= '0;
    end else begin
      v    <= {v[DEPTH-2:0], in_valid};
      f    <= {f[DEPTH-2:0], in_first};
      l    <= {l[DEPTH-2:0], in_last};
      a[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) a[i] <= a[i-1];
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_first = f[DEPTH-1];
  assign out_last  = l[DEPTH-1];
  assign out_addr  = a[DEPTH-1];
  assign empty     = ~|v;

endmodule

// File: rtl/renkon_conv_ctrl.sv
// rtl/renkon_conv_ctrl.sv - 5x5 convolution sequencer, latency tracker and channel accumulator
//
// Purpose: walks every output position (oy, ox) and input channel, issuing
// one window per cycle, then sums the per-channel tree results into one
// saturated output pixel written with its address.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req, ack, busy              layer start pulse / completion pulse / in-progress
//   img_size [SWIDTH]           square input size, captured with req
//   n_in     [CWIDTH]           input channel count (0 behaves as 1)
//   win_valid, win_row, win_col, win_ch   window request to the buffer
//   fmap     [DWIDTH]           signed tree result
//   out_valid, out_data, out_addr         output pixel to the writer
module renkon_conv_ctrl
  import renkon_conv_ctrl_pkg::*;
#(
  parameter int SWIDTH = 8,
  parameter int CWIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [SWIDTH-1:0]        img_size,
  input  logic [CWIDTH-1:0]        n_in,
  output logic                     ack,
  output logic                     busy,
  output logic                     win_valid,
  output logic [SWIDTH-1:0]        win_row,
  output logic [SWIDTH-1:0]        win_col,
  output logic [CWIDTH-1:0]        win_ch,
  input  logic signed [DWIDTH-1:0] fmap,
  output logic                     out_valid,
  output logic signed [DWIDTH-1:0] out_data,
  output logic [2*SWIDTH-1:0]      out_addr
);

  localparam int AWIDTH = 2 * SWIDTH;

  ctrl_state_t state, state_next;

  logic [SWIDTH-1:0] row, col, o_last;
  logic [CWIDTH-1:0] ch, n_last;
  logic [AWIDTH-1:0] addr;
  logic              ch_end, col_end, row_end, last_win;
  logic              too_small;
  logic [CWIDTH-1:0] n_in_last;

  logic              p_valid, p_first, p_last, pipe_empty;
  logic [AWIDTH-1:0] p_addr;

  logic signed [DWIDTH-1:0] acc, acc_next;

  assign ch_end    = (ch == n_last);
  assign col_end   = (col == o_last);
  assign row_end   = (row == o_last);
  assign last_win  = ch_end && col_end && row_end;
  assign too_small = (img_size < SWIDTH'(FSIZE));
  assign n_in_last = (n_in == '0) ? '0 : n_in - CWIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A too-small image still passes through DRAIN (pipeline already empty)
  // so its ack lands two cycles after req, like a zero-window layer would.
  always_comb begin
    state_next = state;
    win_valid  = 1'b0;
    ack        = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) state_next = too_small ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        if (last_win) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // The last tag leaves the line the cycle its out_valid is
        // registered, so an empty line means the final pixel is out.
        if (pipe_empty) state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        ack        = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Loop order oy (row), ox (col), ch innermost; addr counts output pixels
  // so it equals oy*osize+ox without a multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      row    <= '0;
      col    <= '0;
      ch     <= '0;
      addr   <= '0;
      o_last <= '0;
      n_last <= '0;
    end else if (state == S_IDLE && req) begin
      o_last <= img_size - SWIDTH'(FSIZE);
      n_last <= n_in_last;
      row    <= '0;
      col    <= '0;
      ch     <= '0;
      addr   <= '0;
    end else if (win_valid) begin
      if (ch_end) begin
        ch   <= '0;
        addr <= addr + AWIDTH'(1);
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + SWIDTH'(1);
        end else begin
          col <= col + SWIDTH'(1);
        end
      end else begin
        ch <= ch + CWIDTH'(1);
      end
    end
  end

  assign win_row = row;
  assign win_col = col;
  assign win_ch  = ch;

  renkon_conv_ctrl_pipe #(
    .DEPTH  (BUF_LAT + TREE_LAT),
    .AWIDTH (AWIDTH)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (win_valid),
    .in_first  (ch == '0),
    .in_last   (ch_end),
    .in_addr   (addr),
    .out_valid (p_valid),
    .out_first (p_first),
    .out_last  (p_last),
    .out_addr  (p_addr),
    .empty     (pipe_empty)
  );

  assign acc_next = p_first ? fmap : sat_add(acc, fmap);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (p_valid) begin
        acc <= acc_next;
        if (p_last) begin
          out_valid <= 1'b1;
          out_data  <= acc_next;
          out_addr  <= p_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_renkon_conv_ctrl.sv
// tb/tb_renkon_conv_ctrl.sv - scoreboard bench for the convolution sequencer
module tb_renkon_conv_ctrl;

  logic               clk;
  logic               rst;
  logic               req;
  logic [7:0]         img_size;
  logic [9:0]         n_in;
  logic               ack;
  logic               busy;
  logic               win_valid;
  logic [7:0]         win_row;
  logic [7:0]         win_col;
  logic [9:0]         win_ch;
  logic signed [15:0] fmap;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic [15:0]        out_addr;

  renkon_conv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .img_size  (img_size),
    .n_in      (n_in),
    .ack       (ack),
    .busy      (busy),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_ch    (win_ch),
    .fmap      (fmap),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int row; int col; int ch;} win_t;
  typedef struct {int addr; int data;} pix_t;

  win_t win_q[$];
  pix_t out_q[$];
  win_t w_exp;
  pix_t p_exp;

  int n_checks = 0;
  int n_pass   = 0;
  int win_seen = 0;
  int out_seen = 0;

  // Tree stand-in: value of the window issued six cycles earlier.
  int fmap_mode  = 0;
  int fmap_const = 0;
  int ch_d [6];
  logic [15:0] fmap_calc;

  always @(posedge clk) begin
    ch_d[0] <= int'(win_ch);
    for (int i = 5; i > 0; i--) ch_d[i] <= ch_d[i-1];
  end

  always_comb begin
    fmap_calc = 16'(fmap_const);
    if (fmap_mode != 0) fmap_calc = 16'((ch_d[5] + 1) * 10);
  end
  assign fmap = fmap_calc;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a window or pixel.
  always @(negedge clk) begin
    if (win_valid) begin
      win_seen++;
      if (win_q.size() == 0) begin
        check("win_unexpected", 1, 0);
      end else begin
        w_exp = win_q.pop_front();
        check("win_row", int'(win_row), w_exp.row);
        check("win_col", int'(win_col), w_exp.col);
        check("win_ch", int'(win_ch), w_exp.ch);
      end
    end
    if (out_valid) begin
      out_seen++;
      if (out_q.size() == 0) begin
        check("out_unexpected", 1, 0);
      end else begin
        p_exp = out_q.pop_front();
        check("out_addr", int'(out_addr), p_exp.addr);
        check("out_data", int'(out_data), p_exp.data);
      end
    end
  end

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic push_expect(input int img, input int nin, input int mode, input int fval);
    int osz, nch, sum, v;
    nch = (nin == 0) ? 1 : nin;
    osz = (img >= 5) ? img - 4 : 0;
    for (int oy = 0; oy < osz; oy++) begin
      for (int ox = 0; ox < osz; ox++) begin
        sum = 0;
        for (int c = 0; c < nch; c++) begin
          v = (mode != 0) ? (c + 1) * 10 : fval;
          sum = (c == 0) ? v : clamp16(sum + v);
          win_q.push_back('{row: oy, col: ox, ch: c});
        end
        out_q.push_back('{addr: oy * osz + ox, data: sum});
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, int'(ack), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_win_valid"}, int'(win_valid), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_win_row"}, int'(win_row), 0);
    check({tag, "_win_col"}, int'(win_col), 0);
    check({tag, "_win_ch"}, int'(win_ch), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_addr"}, int'(out_addr), 0);
  endtask

  // One layer: req in cycle t, ack expected at t+k. With poke set, a second
  // req carrying a different size is pulsed in cycle t+3 and must be ignored.
  task automatic run_layer(input int img, input int nin, input int mode,
                           input int fval, input bit poke);
    int osz, nch, n_win, k, exp_k;
    bit got;
    nch   = (nin == 0) ? 1 : nin;
    osz   = (img >= 5) ? img - 4 : 0;
    n_win = osz * osz * nch;
    exp_k = (img < 5) ? 2 : n_win + 8;
    fmap_mode  = mode;
    fmap_const = fval;
    push_expect(img, nin, mode, fval);
    win_seen = 0;
    out_seen = 0;
    @(negedge clk);
    img_size = 8'(img);
    n_in     = 10'(nin);
    req      = 1'b1;
    @(negedge clk);
    req = 1'b0;
    k   = 1;
    check("busy_after_req", int'(busy), 1);
    check("first_win_valid", int'(win_valid), (n_win > 0) ? 1 : 0);
    got = 1'b0;
    while (k < 2000 && !got) begin
      if (ack) begin
        got = 1'b1;
      end else begin
        if (poke && k == 3) begin
          req      = 1'b1;
          img_size = 8'd9;
          n_in     = 10'd1;
        end
        @(negedge clk);
        req      = 1'b0;
        img_size = 8'(img);
        n_in     = 10'(nin);
        k++;
      end
    end
    check("ack_seen", int'(got), 1);
    check("ack_latency", k, exp_k);
    @(negedge clk);
    check("ack_one_cycle", int'(ack), 0);
    check("busy_after_ack", int'(busy), 0);
    repeat (2) @(negedge clk);
    check("win_q_drained", win_q.size(), 0);
    check("out_q_drained", out_q.size(), 0);
    check("win_count", win_seen, n_win);
    check("out_count", out_seen, osz * osz);
  endtask

  task automatic reset_mid_run();
    int acks;
    fmap_mode  = 0;
    fmap_const = 1000;
    push_expect(7, 2, 0, 1000);
    @(negedge clk);
    img_size = 8'd7;
    n_in     = 10'd2;
    req      = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("post_rst");
    win_q.delete();
    out_q.delete();
    out_seen = 0;
    win_seen = 0;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      acks += int'(ack);
    end
    check("post_rst_acks", acks, 0);
    check("post_rst_outs", out_seen, 0);
    check("post_rst_wins", win_seen, 0);
  endtask

  initial begin
    rst      = 1'b1;
    req      = 1'b0;
    img_size = '0;
    n_in     = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_layer(5, 1, 0, 123, 1'b0);
    run_layer(6, 2, 1, 0, 1'b0);
    run_layer(5, 3, 0, 30000, 1'b0);
    run_layer(5, 3, 0, -30000, 1'b0);
    run_layer(4, 2, 0, 7, 1'b0);
    run_layer(5, 0, 0, -5, 1'b0);
    reset_mid_run();
    run_layer(5, 1, 0, 77, 1'b0);
    run_layer(6, 2, 0, 100, 1'b1);
    run_layer(7, 1, 0, 20000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
